// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side instruction issuer: FSM encoding,
// idle-bus word default and hold-counter width.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } issuer_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Hold counter must represent HOLD_CYCLES up to 15.
    localparam int unsigned HOLD_W = 4;

    function automatic logic [HOLD_W-1:0] hold_limit(input int unsigned cycles);
        return HOLD_W'(cycles);
    endfunction

endpackage

// File: rtl/instr_buf.sv
// Program buffer: one write port, one synchronous read port, no reset.
// A write to the address being read returns the new word on the read port.
module instr_buf
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_issuer.sv
// Streams a loaded program word-by-word onto a CPU instruction bus, holding
// each word for HOLD_CYCLES cycles, with start/abort control and done pulse.
module instr_issuer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   instruction,
    output logic          issue_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0]       DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_MAX = hold_limit(HOLD_CYCLES);

    issuer_state_e     state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW:0]       len_q, len_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       instruction_q, instruction_d;
    logic              issue_valid_q, issue_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic [31:0]       rd_data;
    logic [AW:0]       pc_next_ext;

    assign wr_en       = load_en && (state_q == IDLE);
    assign pc_next_ext = {1'b0, pc_q} + (AW+1)'(1);

    // The buffer always prefetches the word that would be issued next:
    // index 0 while idle, pc+1 while issuing, so it is ready at hold end.
    always_comb begin
        rd_addr = '0;
        if (!rst && (state_d == ISSUE)) begin
            rd_addr = pc_d + AW'(1);
        end
    end

    instr_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        hold_d        = hold_q;
        instruction_d = instruction_q;
        issue_valid_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                instruction_d = NOP_WORD;
                busy_d        = 1'b0;
                if (start) begin
                    if (prog_len == '0) begin
                        state_d = DONE;
                        len_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        len_d         = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        pc_d          = '0;
                        hold_d        = HOLD_W'(1);
                        issue_valid_d = 1'b1;
                        busy_d        = 1'b1;
                        // Same-cycle load to word 0 must be seen by this run.
                        instruction_d = (load_en && (load_addr == '0)) ? load_data : rd_data;
                    end
                end
            end

            ISSUE: begin
                if (abort) begin
                    state_d       = IDLE;
                    instruction_d = NOP_WORD;
                    busy_d        = 1'b0;
                    hold_d        = '0;
                end else if (hold_q == HOLD_MAX) begin
                    if (pc_next_ext < len_q) begin
                        pc_d          = pc_q + AW'(1);
                        hold_d        = HOLD_W'(1);
                        issue_valid_d = 1'b1;
                        instruction_d = rd_data;
                    end else begin
                        state_d       = DONE;
                        instruction_d = NOP_WORD;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        hold_d        = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            DONE: begin
                state_d       = IDLE;
                instruction_d = NOP_WORD;
                busy_d        = 1'b0;
            end

            default: begin
                state_d       = IDLE;
                instruction_d = NOP_WORD;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            hold_q        <= '0;
            instruction_q <= NOP_WORD;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            hold_q        <= hold_d;
            instruction_q <= instruction_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign instruction = instruction_q;
    assign issue_valid = issue_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer (DEPTH=8, HOLD_CYCLES=4).
module tb_instr_issuer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned AW    = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic [31:0]   instruction;
    logic          issue_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    int total_checks = 0;
    int bad_checks   = 0;
    logic [31:0] mem_model [DEPTH];

    instr_issuer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .instruction (instruction),
        .issue_valid (issue_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the sampling edge.
    task automatic applyStimulus(input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                                 input logic st, input logic [AW:0] pl, input logic ab, input logic rs);
        load_en   = le;
        load_addr = la;
        load_data = ld;
        start     = st;
        prog_len  = pl;
        abort     = ab;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_instr"}, instruction, NOP);
        checkOutput({tag, "_valid"}, 32'(issue_valid), 32'd0);
        checkOutput({tag, "_pc"},    32'(pc),          32'd0);
        checkOutput({tag, "_busy"},  32'(busy),        32'd0);
        checkOutput({tag, "_done"},  32'(done),        32'd0);
    endtask

    // Called just after the accepting start edge; walks the whole run.
    task automatic checkRun(input string tag, input int n);
        int idx;
        for (int c = 1; c <= n*HOLD + 1; c++) begin
            if (c <= n*HOLD) begin
                idx = (c - 1) / HOLD;
                checkOutput($sformatf("%s_instr_c%0d", tag, c), instruction, mem_model[idx]);
                checkOutput($sformatf("%s_valid_c%0d", tag, c), 32'(issue_valid), 32'(((c - 1) % HOLD) == 0));
                checkOutput($sformatf("%s_pc_c%0d", tag, c),    32'(pc),   32'(idx));
                checkOutput($sformatf("%s_busy_c%0d", tag, c),  32'(busy), 32'd1);
                checkOutput($sformatf("%s_done_c%0d", tag, c),  32'(done), 32'd0);
            end else begin
                checkOutput($sformatf("%s_instr_c%0d", tag, c), instruction, NOP);
                checkOutput($sformatf("%s_valid_c%0d", tag, c), 32'(issue_valid), 32'd0);
                checkOutput($sformatf("%s_pc_c%0d", tag, c),    32'(pc),   32'(n - 1));
                checkOutput($sformatf("%s_busy_c%0d", tag, c),  32'(busy), 32'd0);
                checkOutput($sformatf("%s_done_c%0d", tag, c),  32'(done), 32'd1);
            end
            idleCycle();
        end
        checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkReset("reset");

        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i] = 32'h1111_0000 * (i + 1) + 32'(i);
            applyStimulus(1'b1, AW'(i), mem_model[i], 1'b0, '0, 1'b0, 1'b0);
        end
        idleCycle();

        // Basic three-word program.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b0);
        checkRun("run3", 3);

        // Empty program: done pulse only.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd0, 1'b0, 1'b0);
        checkOutput("len0_done",  32'(done),        32'd1);
        checkOutput("len0_valid", 32'(issue_valid), 32'd0);
        checkOutput("len0_instr", instruction,      NOP);
        checkOutput("len0_busy",  32'(busy),        32'd0);
        idleCycle();
        checkOutput("len0_done2",  32'(done),        32'd0);
        checkOutput("len0_valid2", 32'(issue_valid), 32'd0);
        checkOutput("len0_instr2", instruction,      NOP);

        // Abort on the second cycle of word B.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < HOLD; i++) idleCycle();
        checkOutput("abort_b_first", instruction, mem_model[1]);
        checkOutput("abort_b_valid", 32'(issue_valid), 32'd1);
        idleCycle();
        checkOutput("abort_b_second", instruction, mem_model[1]);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("abort_instr", instruction, NOP);
        checkOutput("abort_busy",  32'(busy),   32'd0);
        checkOutput("abort_done",  32'(done),   32'd0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
        end

        // Reset on cycle 6 of a run, then restart.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idleCycle();
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        checkReset("rst_mid");
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd1, 1'b0, 1'b0);
        checkRun("restart", 1);

        // Load while busy is ignored.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, '0, 32'hBAD0_BAD0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("busyload_hold", instruction, mem_model[0]);
        for (int i = 0; i < 2*HOLD; i++) idleCycle();
        checkOutput("busyload_idle", 32'(busy), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd1, 1'b0, 1'b0);
        checkRun("busyload_rerun", 1);

        // Load to word 0 in the same cycle as start.
        mem_model[0] = 32'h5555_0005;
        applyStimulus(1'b1, '0, mem_model[0], 1'b1, 4'd2, 1'b0, 1'b0);
        checkRun("loadstart", 2);

        // Over-long program is clamped to DEPTH words.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'(DEPTH + 1), 1'b0, 1'b0);
        checkRun("clamp", DEPTH);

        // Abort in IDLE does not block start; abort then stops the run.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 1'b1, 1'b0);
        checkOutput("idleabort_busy",  32'(busy),        32'd1);
        checkOutput("idleabort_valid", 32'(issue_valid), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("idleabort_stop", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("idleabort_nodone", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter DEPTH, default 64: program buffer depth in 32-bit words (power of two).
REQ-002 Parameter HOLD_CYCLES, default 4: cycles each instruction is held on the CPU instruction bus (min 1, max 15).
REQ-003 Parameter NOP_WORD, default 32'h0000_0000: word driven when no instruction is being issued.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  write load_data into buffer at load_addr (honoured in IDLE only).
REQ-007 load_addr  input  log2(DEPTH)  buffer write address.
REQ-008 load_data  input  32  instruction word to store.
REQ-009 prog_len  input  log2(DEPTH)+1  instruction count, sampled on accepted start.
REQ-010 start  input  1  begin issuing from address 0 (honoured in IDLE only).
REQ-011 abort  input  1  stop issuing immediately.
REQ-012 instruction  output  32  registered word driven to the CPU instruction port.
REQ-013 issue_valid  output  1  one-cycle pulse on the first cycle a new word appears on instruction.
REQ-014 pc  output  log2(DEPTH)  buffer index of the word currently on instruction.
REQ-015 busy  output  1  high in ISSUE state.
REQ-016 done  output  1  one-cycle pulse after the last instruction's hold completes.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DONE; all outputs registered.
REQ-018 IDLE: instruction=NOP_WORD, busy=0; load_en writes buffer; start with prog_len>0 latches len=min(prog_len,DEPTH) and enters ISSUE.
REQ-019 Cycle after accepted start: instruction=mem[0], pc=0, issue_valid=1, busy=1, hold counter=1.
REQ-020 Each word SHALL remain on instruction for exactly HOLD_CYCLES cycles; issue_valid high only on the first.
REQ-021 After HOLD_CYCLES, if pc+1<len: next cycle instruction=mem[pc+1], pc incremented, issue_valid=1.
REQ-022 After the last word's hold: enter DONE; instruction=NOP_WORD, busy=0, done=1 for one cycle; then IDLE.
REQ-023 start with prog_len=0: go directly to DONE (done pulse next cycle), no word issued.
REQ-024 prog_len>DEPTH SHALL be clamped to DEPTH; pc never wraps within a run.
REQ-025 load_en and start while not IDLE SHALL be ignored; buffer contents unchanged.
REQ-026 load_en and start in the same IDLE cycle: write occurs, and the run reads the new value if load_addr=0.
REQ-027 abort in ISSUE: next cycle instruction=NOP_WORD, busy=0, IDLE, no done pulse; abort has priority over hold-complete.
REQ-028 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-029 rst SHALL force IDLE, instruction=NOP_WORD, issue_valid=0, pc=0, busy=0, done=0, counters=0 at next edge, including mid-run.
REQ-030 Buffer contents SHALL NOT be cleared by rst.

Structure
REQ-031 State encoding enum and NOP_WORD default in shared package cpu_pkg.
REQ-032 Program buffer SHALL be one sub-module, instr_buf (1 write port, 1 synchronous read port, no reset).

Verification
REQ-033 Load 3 words A,B,C; start, prog_len=3 -> A for 4 cycles, B for 4, C for 4; issue_valid at cycles 1,5,9; done at cycle 13.
REQ-034 start, prog_len=0 -> done pulse next cycle; issue_valid never asserted; instruction stays NOP_WORD.
REQ-035 abort on 2nd cycle of word B -> NOP_WORD next cycle, busy=0, no done pulse.
REQ-036 rst on cycle 6 of a run -> all outputs at reset values next edge; restart -> mem[0] reissued unchanged.
REQ-037 load_en to addr 0 during busy -> ignored; next run issues original mem[0].
REQ-038 prog_len=DEPTH+1 -> exactly DEPTH words issued, pc ends at DEPTH-1, done pulse.
